// File: rtl/instr_encode_loader.sv
// ============================================================================
// instr_encode_loader
// ----------------------------------------------------------------------------
// Turns instruction field bundles (LW, I-type ALU, SW, R-type, BEQ) into
// 32-bit RV32I words, queues them in a small FIFO and writes them one per
// cycle into instruction memory starting at BASE_ADDR. While a session is in
// progress core_hold keeps the single-cycle core in reset.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle pulse that opens a load session (IDLE only)
//   in_valid_i     field bundle valid
//   in_ready_o     bundle accepted when in_valid_i & in_ready_o
//   in_last_i      marks the final bundle of the session
//   in_class_i     000 LW, 001 I-type, 010 SW, 011 R-type, 100 BEQ
//   in_funct3_i    funct3 (I/R only; LW/SW use 010, BEQ uses 000)
//   in_funct7_i    funct7 (R-type, and I-type shifts)
//   in_rd_i        destination register
//   in_rs1_i       source register 1
//   in_rs2_i       source register 2
//   in_imm_i       two's-complement immediate (BEQ uses [12:1])
//   imem_we_o      instruction-memory write strobe
//   imem_addr_o    word address of the write
//   imem_wdata_o   encoded instruction
//   core_hold_o    holds the core in reset while loading
//   done_o         one-cycle pulse when the session completes
//   err_o          sticky illegal-class / address-overflow flag
// ============================================================================
module instr_encode_loader #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_last_i,
    input  logic [2:0]        in_class_i,
    input  logic [2:0]        in_funct3_i,
    input  logic [6:0]        in_funct7_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [12:0]       in_imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]       NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fifo_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               hold_q, hold_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        enc_word;
    logic               enc_illegal;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;

    // Field-to-word encoder. Unknown classes become a NOP so the core
    // still has something harmless at that address.
    always_comb begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b0;
        unique case (in_class_i)
            3'b000: enc_word = {in_imm_i[11:0], in_rs1_i, 3'b010, in_rd_i, 7'b0000011};
            3'b001: begin
                if (in_funct3_i == 3'b001 || in_funct3_i == 3'b101) begin
                    enc_word = {in_funct7_i, in_imm_i[4:0], in_rs1_i, in_funct3_i,
                                in_rd_i, 7'b0010011};
                end else begin
                    enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0010011};
                end
            end
            3'b010: enc_word = {in_imm_i[11:5], in_rs2_i, in_rs1_i, 3'b010,
                                in_imm_i[4:0], 7'b0100011};
            3'b011: enc_word = {in_funct7_i, in_rs2_i, in_rs1_i, in_funct3_i,
                                in_rd_i, 7'b0110011};
            3'b100: enc_word = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, 3'b000,
                                in_imm_i[4:1], in_imm_i[11], 7'b1100011};
            default: begin
                enc_word    = NOP_WORD;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // FIFO handshake. The memory side never stalls, so any queued word is
    // popped in LOAD or DRAIN; full only blocks new pushes.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        in_ready_o = (state_q == S_LOAD) && !fifo_full;
        push       = in_valid_i && in_ready_o;
        pop        = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !fifo_empty;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Session sequencing plus the registered write port. Once the last
    // address has been written, later words are dropped and flagged, and
    // the address stays saturated instead of wrapping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_o  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    addr_d  = BASE;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (push && in_last_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push && enc_illegal) begin
            err_d = 1'b1;
        end

        if (pop) begin
            if (ovf_q) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = fifo_q[rd_ptr_q];
                if (addr_q == ADDR_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= BASE;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign core_hold_o  = hold_q;
    assign err_o        = err_q;

endmodule
